alu_serial_seq: RTL and testbench
=================================

// Module: alu_serial_seq
// PURPOSE
//  Word-level sequencer that drives the bit-serial SFQ ALU (X/Y/Carry_in/End/Cmpl_*/Op_* in; Sum/Carry_out/Overflow out).
//  Accepts a parallel command (opcode + two W-bit operands) on a valid/ready handshake and serialises the operands LSB-first.
//  Drives the ALU control lines for the whole word, then collects the returning Sum stream after ALU_LAT cycles.
//  Returns the W-bit result plus carry/overflow flags on a valid/ready response port.
//  Sits between the word-parallel datapath and the bit-serial ALU core.
// PARAMETERS
//  W        16  operand/result width in bits (>=2)
//  ALU_LAT  6   gclk cycles from an operand bit on alu_x/alu_y to its Sum bit on alu_sum (ALU clocked depth)
// PORTS
//  gclk           in   1   clock
//  rst_n          in   1   synchronous reset, active low
//  cmd_valid      in   1   command present
//  cmd_ready      out  1   sequencer idle, command accepted when valid&ready
//  cmd_op         in   3   000 ADD, 001 SUB (X-Y), 010 RSUB (Y-X), 011 AND, 100 XOR, 101 NOR; 110/111 illegal
//  cmd_x, cmd_y   in   W   operands
//  alu_x, alu_y   out  1   serial operand bits, LSB first
//  alu_carry_in   out  1   carry seed, bit 0 only
//  alu_end        out  1   last-bit marker
//  alu_cmpl_x/_y  out  1   operand complement controls
//  alu_op_xor/_and/_arith out 1  function select, one-hot
//  alu_sum        in   1   serial result bit
//  alu_carry_out  in   1   carry, valid with the End-aligned Sum bit
//  alu_overflow   in   1   signed overflow, valid with the End-aligned Sum bit
//  rsp_valid      out  1   response present
//  rsp_ready      in   1   response consumed when valid&ready
//  rsp_result     out  W   collected result
//  rsp_carry, rsp_ovf, rsp_err out 1  flags; err = illegal opcode
// BEHAVIOUR
//  Reset: cmd_ready=1, rsp_valid=0, rsp_result=0, all flags 0, every alu_* output 0, tag pipeline cleared.
//  FSM: IDLE -> SEND (W cycles) -> DRAIN (until last tagged bit returns) -> RESP (hold until rsp_ready) -> IDLE.
//  cmd_ready=1 only in IDLE. A cmd accepted in cycle c drives bit i on alu_x/alu_y in cycle c+1+i.
//  All alu_* outputs are registered. Control decode is held constant for all W SEND cycles and is 0 outside SEND:
//   ADD: arith. SUB: arith, cmpl_y, carry_in=1. RSUB: arith, cmpl_x, carry_in=1.
//   AND: and. XOR: xor. NOR: and, cmpl_x, cmpl_y.
//  alu_carry_in is 1 only on bit 0. alu_end is 1 only on bit W-1.
//  Tag pipeline is ALU_LAT deep and carries {valid,last} per driven bit.
//   When a valid tag emerges, alu_sum is shifted into result MSB with a right shift, so after W bits bit0 sits at LSB.
//   When a last tag emerges, alu_carry_out and alu_overflow are latched; rsp_valid rises the next cycle.
//  Latency: rsp_valid first high in cycle c+W+ALU_LAT+1.
//  Flags are forced to 0 for AND/XOR/NOR; the ALU values are ignored.
//  Untagged alu_* inputs are ignored, including stale outputs after reset.
//  Illegal opcode: accepted; no SEND; next cycle RESP with rsp_err=1, result 0, carry/ovf 0.
//  RESP: rsp_* stable while rsp_valid & !rsp_ready. Handshake cycle -> IDLE, cmd_ready=1 next cycle.
//  No overlap: one operation in flight.
//  rst_n low in any state aborts the operation within one cycle and restores reset values. No partial response.
// CONFIGURATION
//  ALU_SEQ_ZFLAG_EN defined:
//   adds output rsp_zero (1 bit), computed as a serial NOR of all collected Sum bits.
//   rsp_zero is valid with rsp_valid, is 1 for an illegal op, and resets to 0.
//  Not defined: port absent and no zero logic.
// TESTING (bench includes a behavioural bit-serial ALU model with ALU_LAT delay; W=16)
//  ADD 0x1234,0x0001 -> result 0x1235, carry 0, ovf 0, rsp_valid at c+23.
//  ADD 0xFFFF,0x0001 -> 0x0000, carry 1. ADD 0x7FFF,0x0001 -> 0x8000, ovf 1.
//  SUB 0x0000,0x0001 -> 0xFFFF, carry 0; alu_carry_in high only on the bit-0 cycle; alu_end high only on bit 15.
//  AND 0xF0F0,0x3C3C -> 0x3030; NOR 0xF0F0,0x0F0F -> 0x0000 (zero=1 if ZFLAG).
//  rsp_ready held low 10 cycles -> rsp_* stable, cmd_ready=0; second cmd accepted only after the handshake.
//  rst_n low mid-SEND (bit 7), then ADD 1,1 -> exactly one response of 0x0002; op 110 -> err=1 at c+2.

Source files
------------

// File: rtl/alu_serial_seq.sv
// Word-level sequencer for a bit-serial ALU: serialises operands LSB-first, drives the ALU
// control lines, collects the delayed Sum stream and returns the word. Option: ALU_SEQ_ZFLAG_EN adds rsp_zero.
module alu_serial_seq #(
  parameter int W       = 16,
  parameter int ALU_LAT = 6
) (
  input  logic         gclk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_x,
  input  logic [W-1:0] cmd_y,
  output logic         alu_x,
  output logic         alu_y,
  output logic         alu_carry_in,
  output logic         alu_end,
  output logic         alu_cmpl_x,
  output logic         alu_cmpl_y,
  output logic         alu_op_xor,
  output logic         alu_op_and,
  output logic         alu_op_arith,
  input  logic         alu_sum,
  input  logic         alu_carry_out,
  input  logic         alu_overflow,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_ovf,
  output logic         rsp_err
`ifdef ALU_SEQ_ZFLAG_EN
  ,
  output logic         rsp_zero
`endif
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, RESP} state_t;

  typedef struct packed {
    logic arith;
    logic op_and;
    logic op_xor;
    logic cmpl_x;
    logic cmpl_y;
    logic carry_in;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [2:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      3'd0: c.arith = 1'b1;
      3'd1: begin c.arith = 1'b1; c.cmpl_y = 1'b1; c.carry_in = 1'b1; end
      3'd2: begin c.arith = 1'b1; c.cmpl_x = 1'b1; c.carry_in = 1'b1; end
      3'd3: c.op_and = 1'b1;
      3'd4: c.op_xor = 1'b1;
      3'd5: begin c.op_and = 1'b1; c.cmpl_x = 1'b1; c.cmpl_y = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t              state, state_nxt;
  ctrl_t               ctrl_now;
  logic                legal, accept, load_cmd, collect, tag_done, last_bit;
  logic [CW-1:0]       bit_cnt;
  logic [W-1:0]        x_sh, y_sh;
  logic                drive_vld, arith_op;
  logic [ALU_LAT-1:0]  tag_vld, tag_last;

  assign ctrl_now = decode(cmd_op);
  assign legal    = (cmd_op <= 3'd5);
  assign last_bit = (bit_cnt == CW'(W - 1));

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge gclk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = legal ? SEND : RESP;
      SEND:    if (last_bit) state_nxt = DRAIN;
      DRAIN:   if (tag_done) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    collect   = 1'b0;
    cmd_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    collect   = ((state == SEND) || (state == DRAIN)) && tag_vld[ALU_LAT-1];
  end

  assign accept   = cmd_valid & cmd_ready;
  assign load_cmd = accept & legal;
  assign tag_done = collect & tag_last[ALU_LAT-1];

  // Operand serialiser and ALU control; decode is frozen for the whole word.
  // NOTE: the tag pipeline is reset too, so stale ALU output after reset can never look tagged.
  always_ff @(posedge gclk) begin
    if (!rst_n) begin
      {alu_x, alu_y, alu_carry_in, alu_end}              <= '0;
      {alu_cmpl_x, alu_cmpl_y}                           <= '0;
      {alu_op_xor, alu_op_and, alu_op_arith}             <= '0;
      x_sh      <= '0;
      y_sh      <= '0;
      bit_cnt   <= '0;
      drive_vld <= 1'b0;
      arith_op  <= 1'b0;
      tag_vld   <= '0;
      tag_last  <= '0;
    end else begin
      tag_vld  <= (tag_vld << 1) | ALU_LAT'(drive_vld);
      tag_last <= (tag_last << 1) | ALU_LAT'(drive_vld & alu_end);
      if (load_cmd) begin
        alu_x        <= cmd_x[0];
        alu_y        <= cmd_y[0];
        x_sh         <= cmd_x >> 1;
        y_sh         <= cmd_y >> 1;
        bit_cnt      <= '0;
        drive_vld    <= 1'b1;
        alu_end      <= 1'b0;
        alu_carry_in <= ctrl_now.carry_in;
        alu_cmpl_x   <= ctrl_now.cmpl_x;
        alu_cmpl_y   <= ctrl_now.cmpl_y;
        alu_op_xor   <= ctrl_now.op_xor;
        alu_op_and   <= ctrl_now.op_and;
        alu_op_arith <= ctrl_now.arith;
        arith_op     <= ctrl_now.arith;
      end else if (state == SEND) begin
        if (!last_bit) begin
          alu_x        <= x_sh[0];
          alu_y        <= y_sh[0];
          x_sh         <= x_sh >> 1;
          y_sh         <= y_sh >> 1;
          bit_cnt      <= bit_cnt + 1'b1;
          alu_carry_in <= 1'b0;
          alu_end      <= (bit_cnt == CW'(W - 2));
        end else begin
          {alu_x, alu_y, alu_carry_in, alu_end}  <= '0;
          {alu_cmpl_x, alu_cmpl_y}               <= '0;
          {alu_op_xor, alu_op_and, alu_op_arith} <= '0;
          drive_vld <= 1'b0;
        end
      end
    end
  end

  // Result collector: Sum bits enter at the MSB, so bit 0 ends at the LSB after W shifts.
  always_ff @(posedge gclk) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (accept) begin
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= ~legal;
    end else if (collect) begin
      rsp_result <= {alu_sum, rsp_result[W-1:1]};
      if (tag_last[ALU_LAT-1]) begin
        rsp_carry <= arith_op & alu_carry_out;
        rsp_ovf   <= arith_op & alu_overflow;
      end
    end
  end

`ifdef ALU_SEQ_ZFLAG_EN
  always_ff @(posedge gclk) begin
    if (!rst_n)       rsp_zero <= 1'b0;
    else if (accept)  rsp_zero <= 1'b1;
    else if (collect) rsp_zero <= rsp_zero & ~alu_sum;
  end
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq: bit-serial ALU model with ALU_LAT delay, word-level reference
// model, per-cycle compare of ALU lines and responses, plus directed literal expectations.
module tb_alu_serial_seq;
  localparam int W   = 16;
  localparam int LAT = 6;

  logic         gclk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [2:0]   cmd_op = '0;
  logic [W-1:0] cmd_x = '0, cmd_y = '0;
  logic         rsp_ready = 1'b1;
  logic         cmd_ready, rsp_valid, rsp_carry, rsp_ovf, rsp_err;
  logic [W-1:0] rsp_result;
  logic         alu_x, alu_y, alu_carry_in, alu_end, alu_cmpl_x, alu_cmpl_y;
  logic         alu_op_xor, alu_op_and, alu_op_arith;
  logic         alu_sum, alu_carry_out, alu_overflow;
`ifdef ALU_SEQ_ZFLAG_EN
  logic         rsp_zero;
`endif

  alu_serial_seq #(.W(W), .ALU_LAT(LAT)) dut (
    .gclk(gclk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .alu_x(alu_x), .alu_y(alu_y), .alu_carry_in(alu_carry_in), .alu_end(alu_end),
    .alu_cmpl_x(alu_cmpl_x), .alu_cmpl_y(alu_cmpl_y),
    .alu_op_xor(alu_op_xor), .alu_op_and(alu_op_and), .alu_op_arith(alu_op_arith),
    .alu_sum(alu_sum), .alu_carry_out(alu_carry_out), .alu_overflow(alu_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
`ifdef ALU_SEQ_ZFLAG_EN
    , .rsp_zero(rsp_zero)
`endif
  );

  always #5 gclk = ~gclk;

  typedef struct {
    int           acc;
    int           lat;
    logic [W-1:0] res;
    logic         c, v, e, z;
    bit           seen;
  } exp_t;

  exp_t         q[$];
  int           checks = 0, errors = 0, cyc = 0;
  int           cur_acc = -1;
  logic [2:0]   cur_op = '0;
  logic [W-1:0] cur_x = '0, cur_y = '0;
  int           resp_count = 0, hs_cyc = -1, first_cyc = -1, first_acc = -1;
  logic [W-1:0] got_res = '0;
  logic         got_c = 1'b0, got_v = 1'b0, got_e = 1'b0, got_z = 1'b0;
  bit           mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // {arith, and, xor, cmpl_x, cmpl_y, carry_in} per opcode
  function automatic logic [5:0] ctl(input logic [2:0] op);
    case (op)
      3'd0: return 6'b100000;
      3'd1: return 6'b100011;
      3'd2: return 6'b100101;
      3'd3: return 6'b010000;
      3'd4: return 6'b001000;
      3'd5: return 6'b010110;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int acc);
    exp_t m;
    logic [W:0] s;
    m.acc = acc; m.lat = W + LAT + 1; m.res = '0;
    m.c = 1'b0; m.v = 1'b0; m.e = 1'b0; m.seen = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, x} + {1'b0, y};
        m.res = s[W-1:0]; m.c = s[W];
        m.v = (x[W-1] == y[W-1]) && (m.res[W-1] != x[W-1]);
      end
      3'd1: begin
        s = {1'b0, x} + {1'b0, ~y} + 1;
        m.res = s[W-1:0]; m.c = s[W];
        m.v = (x[W-1] != y[W-1]) && (m.res[W-1] != x[W-1]);
      end
      3'd2: begin
        s = {1'b0, y} + {1'b0, ~x} + 1;
        m.res = s[W-1:0]; m.c = s[W];
        m.v = (y[W-1] != x[W-1]) && (m.res[W-1] != y[W-1]);
      end
      3'd3: m.res = x & y;
      3'd4: m.res = x ^ y;
      3'd5: m.res = ~(x | y);
      default: begin m.e = 1'b1; m.lat = 1; end
    endcase
    m.z = (m.res == '0);
    return m;
  endfunction

  // Bit-serial ALU: result of the bit seen in cycle t appears on alu_sum in cycle t+LAT.
  logic [LAT:0] sp = '0, cp = '0, vp = '0;
  logic         car = 1'b0;
  assign alu_sum       = sp[LAT];
  assign alu_carry_out = cp[LAT];
  assign alu_overflow  = vp[LAT];

  always @(negedge gclk) begin : alu_model
    logic a, b, cin, s, co;
    a   = alu_x ^ alu_cmpl_x;
    b   = alu_y ^ alu_cmpl_y;
    cin = car | alu_carry_in;
    co  = (a & b) | (a & cin) | (b & cin);
    if (alu_op_arith)    s = a ^ b ^ cin;
    else if (alu_op_and) s = a & b;
    else if (alu_op_xor) s = a ^ b;
    else                 s = 1'b0;
    sp = {sp[LAT-1:0], s};
    cp = {cp[LAT-1:0], alu_op_arith & co};
    vp = {vp[LAT-1:0], alu_op_arith & (cin ^ co)};
    car = (!rst_n || alu_end || !alu_op_arith) ? 1'b0 : co;
  end

  always @(posedge gclk) begin
    cyc++;
    if (!rst_n) begin
      q.delete();
      cur_acc = -1;
    end
  end

  // Per-cycle compare of ALU lines and the response port.
  always @(negedge gclk) begin : compare
    logic [8:0] exp_alu, act_alu;
    logic [5:0] d;
    int         i;
    if (mon_en) begin
      exp_alu = '0;
      if (cur_acc >= 0 && cur_op <= 3'd5 && cyc >= cur_acc + 1 && cyc <= cur_acc + W) begin
        i = cyc - cur_acc - 1;
        d = ctl(cur_op);
        exp_alu = {cur_x[i], cur_y[i], d[0] && (i == 0), i == W - 1, d[2], d[1], d[3], d[4], d[5]};
      end
      act_alu = {alu_x, alu_y, alu_carry_in, alu_end, alu_cmpl_x, alu_cmpl_y,
                 alu_op_xor, alu_op_and, alu_op_arith};
      check("alu_lines", act_alu, exp_alu);
      if (rsp_valid) begin
        check("cmd_ready_in_resp", cmd_ready, 0);
        if (q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
        else begin
          if (!q[0].seen) begin
            q[0].seen = 1'b1;
            first_cyc = cyc;
            first_acc = q[0].acc;
            check("rsp_latency", cyc - q[0].acc, q[0].lat);
          end
          check("rsp_result", rsp_result, q[0].res);
          check("rsp_flags", {rsp_carry, rsp_ovf, rsp_err}, {q[0].c, q[0].v, q[0].e});
`ifdef ALU_SEQ_ZFLAG_EN
          check("rsp_zero", rsp_zero, q[0].z);
          got_z = rsp_zero;
`endif
          if (rsp_ready) begin
            got_res = rsp_result; got_c = rsp_carry; got_v = rsp_ovf; got_e = rsp_err;
            resp_count++;
            hs_cyc = cyc;
            void'(q.pop_front());
          end
        end
      end else if (q.size() > 0 && !q[0].seen && cyc > q[0].acc + q[0].lat) begin
        check("rsp_missing", rsp_valid, 1);
        q[0].seen = 1'b1;
      end
    end
  end

  // Called one step after a rising edge; returns one step after the accepting edge.
  task automatic send_cmd(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int acc);
    cmd_op = op; cmd_x = x; cmd_y = y; cmd_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge gclk);
      if (cmd_ready === 1'b1) begin
        acc = cyc;
        q.push_back(model(op, x, y, cyc));
        cur_acc = cyc; cur_op = op; cur_x = x; cur_y = y;
      end
      @(posedge gclk); #1;
      if (acc >= 0) break;
    end
    cmd_valid = 1'b0;
    if (acc < 0) check("cmd_accept_timeout", cmd_ready, 1);
  endtask

  task automatic wait_resp(input int n);
    for (int k = 0; k < 300 && resp_count < n; k++) begin
      @(posedge gclk); #1;
    end
    check("rsp_arrived", resp_count >= n, 1);
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] er, input logic ec, input logic ev);
    exp_t m;
    int   n, acc;
    m = model(op, x, y, 0);
    check({name, "_model"}, {m.res, m.c, m.v}, {er, ec, ev});
    n = resp_count;
    send_cmd(op, x, y, acc);
    wait_resp(n + 1);
    check({name, "_result"}, got_res, er);
    check({name, "_flags"}, {got_c, got_v, got_e}, {ec, ev, 1'b0});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin : stim
    int acc, acc_b, n;
    exp_t m;
    repeat (3) @(posedge gclk);
    #1;
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rsp", {rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_err}, '0);
    check("reset_alu", {alu_x, alu_y, alu_carry_in, alu_end, alu_cmpl_x, alu_cmpl_y,
                        alu_op_xor, alu_op_and, alu_op_arith}, '0);
`ifdef ALU_SEQ_ZFLAG_EN
    check("reset_zero", rsp_zero, 0);
`endif
    rst_n  = 1'b1;
    mon_en = 1'b1;

    run_op("add_basic", 3'd0, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0);
    check("add_latency_23", first_cyc - first_acc, 23);
    run_op("add_carry", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",   3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
    run_op("sub_wrap",  3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    run_op("rsub",      3'd2, 16'h0003, 16'h0010, 16'h000D, 1'b1, 1'b0);
    run_op("and",       3'd3, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0);
    run_op("xor",       3'd4, 16'hF0F0, 16'h3C3C, 16'hCCCC, 1'b0, 1'b0);
    run_op("nor",       3'd5, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b0, 1'b0);
`ifdef ALU_SEQ_ZFLAG_EN
    check("nor_zero", got_z, 1);
`endif

    // Response held off 10 cycles while a second command waits.
    n = resp_count;
    rsp_ready = 1'b0;
    send_cmd(3'd0, 16'h0100, 16'h0200, acc);
    fork
      begin
        for (int k = 0; k < 100 && !rsp_valid; k++) @(negedge gclk);
        repeat (10) @(posedge gclk);
        #1 rsp_ready = 1'b1;
      end
      send_cmd(3'd4, 16'h00FF, 16'h0F0F, acc_b);
    join
    check("stall_first_result", got_res, 16'h0300);
    check("second_cmd_after_hs", acc_b, hs_cyc + 1);
    wait_resp(n + 2);
    check("second_result", got_res, 16'h0FF0);

    // Reset during bit 7 of an ADD, then a clean ADD 1,1.
    send_cmd(3'd0, 16'hAAAA, 16'h5555, acc);
    repeat (7) @(posedge gclk);
    #1 rst_n = 1'b0;
    @(posedge gclk);
    #1 rst_n = 1'b1;
    check("abort_ready", {cmd_ready, rsp_valid}, 2'b10);
    n = resp_count;
    run_op("add_after_abort", 3'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0);
    repeat (40) @(posedge gclk);
    #1;
    check("one_rsp_after_abort", resp_count, n + 1);

    // Illegal opcode: immediate error response.
    m = model(3'd6, 16'h1111, 16'h2222, 0);
    check("illegal_model", {m.e, m.res, m.lat[7:0]}, {1'b1, 16'h0000, 8'd1});
    n = resp_count;
    rsp_ready = 1'b0;
    send_cmd(3'd6, 16'h1111, 16'h2222, acc);
    @(negedge gclk);
    check("illegal_c1", {rsp_valid, rsp_err}, 2'b11);
    @(posedge gclk);
    @(negedge gclk);
    check("illegal_c2", {rsp_valid, rsp_err, rsp_result, rsp_carry, rsp_ovf}, {2'b11, 18'h0});
`ifdef ALU_SEQ_ZFLAG_EN
    check("illegal_zero", rsp_zero, 1);
`endif
    @(posedge gclk);
    #1 rsp_ready = 1'b1;
    wait_resp(n + 1);
    check("illegal_flags", {got_e, got_c, got_v}, 3'b100);

    repeat (5) @(posedge gclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
